// File: rtl/insn_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : insn_sequencer
// Purpose  : Multi-cycle instruction sequencer for the pd-series RISC-V core.
//            Steps each instruction through FETCH, DECODE, EXEC, optional MEM
//            and WB. Handshakes with instruction and data memory, latches the
//            decode-stage control bits, counts retired instructions and halts
//            on illegal opcodes or memory ack timeouts.
// Ports    : clk, rst_n (async, active low)
//            opcode_i, regwren_i, memren_i, memwren_i, pcsel_i - sampled in DECODE
//            br_taken_i                                    - sampled in EXEC
//            imem_req_o / imem_ack_i                       - fetch handshake
//            dmem_req_o / dmem_we_o / dmem_ack_i           - data handshake
//            ir_we_o, rf_we_o, pc_we_o, pc_sel_o           - datapath strobes
//            state_o, retire_o, instret_o, halted_o, err_o - status
// Revision : 1.0 - initial release
// ============================================================================
module insn_sequencer #(
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        opcode_i,
  input  logic              regwren_i,
  input  logic              memren_i,
  input  logic              memwren_i,
  input  logic              pcsel_i,
  input  logic              br_taken_i,
  output logic              imem_req_o,
  input  logic              imem_ack_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  input  logic              dmem_ack_i,
  output logic              ir_we_o,
  output logic              rf_we_o,
  output logic              pc_we_o,
  output logic              pc_sel_o,
  output logic [2:0]        state_o,
  output logic              retire_o,
  output logic [DWIDTH-1:0] instret_o,
  output logic              halted_o,
  output logic [1:0]        err_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_IMEM    = 2'b10;
  localparam logic [1:0] ERR_DMEM    = 2'b11;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t              state_q,   state_d;
  logic [15:0]         wait_q,    wait_d;
  logic [6:0]          opcode_q,  opcode_d;
  logic                regwren_q, regwren_d;
  logic                memren_q,  memren_d;
  logic                memwren_q, memwren_d;
  logic                pcsel_q,   pcsel_d;
  logic                br_q,      br_d;
  logic [1:0]          err_q,     err_d;
  logic [DWIDTH-1:0]   instret_q, instret_d;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_OPIMM, OP_OP: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    // Any transition leaves the wait counter at zero; only an un-acked
    // request cycle that stays in place advances it.
    wait_d     = 16'd0;
    opcode_d   = opcode_q;
    regwren_d  = regwren_q;
    memren_d   = memren_q;
    memwren_d  = memwren_q;
    pcsel_d    = pcsel_q;
    br_d       = br_q;
    err_d      = err_q;
    instret_d  = instret_q;

    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    ir_we_o    = 1'b0;
    rf_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    pc_sel_o   = 1'b0;
    retire_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          ir_we_o = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == TIMEOUT_W) begin
          // TIMEOUT un-acked cycles already tolerated; this is one past.
          state_d = S_HALT;
          err_d   = ERR_IMEM;
        end else begin
          wait_d  = wait_q + 16'd1;
        end
      end

      S_DECODE: begin
        opcode_d  = opcode_i;
        regwren_d = regwren_i;
        memren_d  = memren_i;
        memwren_d = memwren_i;
        pcsel_d   = pcsel_i;
        if (is_legal(opcode_i)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          err_d   = ERR_ILLEGAL;
        end
      end

      S_EXEC: begin
        br_d    = (opcode_q == OP_BRANCH) ? br_taken_i : 1'b0;
        state_d = (memren_q | memwren_q) ? S_MEM : S_WB;
      end

      S_MEM: begin
        dmem_req_o = 1'b1;
        // Store wins when both read and write were decoded.
        dmem_we_o  = memwren_q;
        if (dmem_ack_i) begin
          state_d = S_WB;
        end else if (wait_q == TIMEOUT_W) begin
          state_d = S_HALT;
          err_d   = ERR_DMEM;
        end else begin
          wait_d  = wait_q + 16'd1;
        end
      end

      S_WB: begin
        rf_we_o   = regwren_q;
        pc_we_o   = 1'b1;
        // Branches only redirect when the comparison was taken.
        pc_sel_o  = pcsel_q & ((opcode_q != OP_BRANCH) | br_q);
        retire_o  = 1'b1;
        instret_d = instret_q + DWIDTH'(1);
        state_d   = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= 16'd0;
      opcode_q  <= 7'd0;
      regwren_q <= 1'b0;
      memren_q  <= 1'b0;
      memwren_q <= 1'b0;
      pcsel_q   <= 1'b0;
      br_q      <= 1'b0;
      err_q     <= 2'b00;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      opcode_q  <= opcode_d;
      regwren_q <= regwren_d;
      memren_q  <= memren_d;
      memwren_q <= memwren_d;
      pcsel_q   <= pcsel_d;
      br_q      <= br_d;
      err_q     <= err_d;
      instret_q <= instret_d;
    end
  end

  assign state_o   = state_q;
  assign instret_o = instret_q;
  assign halted_o  = (state_q == S_HALT);
  assign err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_insn_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_insn_sequencer
// Purpose  : Directed self-checking bench for insn_sequencer. Each instruction
//            is expanded by a transaction-level model into a per-cycle list of
//            stimulus and expected outputs, which one process drives and checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_insn_sequencer;

  localparam int DW = 4;
  localparam int TO = 4;

  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    opcode_i = '0;
  logic          regwren_i = 1'b0, memren_i = 1'b0, memwren_i = 1'b0, pcsel_i = 1'b0;
  logic          br_taken_i = 1'b0, imem_ack_i = 1'b0, dmem_ack_i = 1'b0;
  logic          imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, rf_we_o, pc_we_o, pc_sel_o;
  logic [2:0]    state_o;
  logic          retire_o, halted_o;
  logic [DW-1:0] instret_o;
  logic [1:0]    err_o;

  insn_sequencer #(.DWIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .opcode_i(opcode_i), .regwren_i(regwren_i), .memren_i(memren_i),
    .memwren_i(memwren_i), .pcsel_i(pcsel_i), .br_taken_i(br_taken_i),
    .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
    .ir_we_o(ir_we_o), .rf_we_o(rf_we_o), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o),
    .state_o(state_o), .retire_o(retire_o), .instret_o(instret_o),
    .halted_o(halted_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    state;
    logic          imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, pc_sel, retire, halted;
    logic [1:0]    err;
    logic [DW-1:0] instret;
  } obs_t;

  typedef struct {
    logic       imem_ack, dmem_ack, drive_dec, drive_exec, br;
    logic [6:0] opcode;
    logic [3:0] ctrl;   // {regwren, memren, memwren, pcsel}
    obs_t       exp;
  } rec_t;

  rec_t q[$];
  int   checks = 0, failures = 0;
  int   model_cnt = 0;
  int   obs_imem = 0, obs_dmem = 0, obs_pcsel = 0;
  int   cyc = 0;

  function automatic obs_t sample();
    return {state_o, imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, rf_we_o, pc_we_o,
            pc_sel_o, retire_o, halted_o, err_o, instret_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  function automatic rec_t mk(input logic [2:0] st);
    rec_t r;
    r.imem_ack = 0; r.dmem_ack = 0; r.drive_dec = 0; r.drive_exec = 0; r.br = 0;
    r.opcode = '0; r.ctrl = '0;
    r.exp = '0;
    r.exp.state = st;
    r.exp.instret = DW'(model_cnt);
    return r;
  endfunction

  function automatic void add_halt(input logic [1:0] code, input int n);
    rec_t r;
    for (int k = 0; k < n; k++) begin
      r = mk(3'd6); r.exp.halted = 1; r.exp.err = code; q.push_back(r);
    end
  endfunction

  function automatic logic legal(input logic [6:0] op);
    return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
  endfunction

  // iw / dw: un-acked wait cycles before the ack; above TO means no ack ever.
  function automatic void add_insn(input logic [6:0] op, input logic rw, input logic mr,
                                   input logic mw, input logic ps, input logic br,
                                   input int iw, input int dw);
    rec_t r;
    if (iw > TO) begin
      for (int k = 0; k <= TO; k++) begin r = mk(3'd1); r.exp.imem_req = 1; q.push_back(r); end
      add_halt(2'b10, 3);
      return;
    end
    for (int k = 0; k <= iw; k++) begin
      r = mk(3'd1); r.exp.imem_req = 1;
      if (k == iw) begin r.imem_ack = 1; r.exp.ir_we = 1; end
      q.push_back(r);
    end
    r = mk(3'd2); r.drive_dec = 1; r.opcode = op; r.ctrl = {rw, mr, mw, ps}; q.push_back(r);
    if (!legal(op)) begin add_halt(2'b01, 3); return; end
    r = mk(3'd3); r.drive_exec = 1; r.br = br; q.push_back(r);
    if (mr || mw) begin
      if (dw > TO) begin
        for (int k = 0; k <= TO; k++) begin
          r = mk(3'd4); r.exp.dmem_req = 1; r.exp.dmem_we = mw; q.push_back(r);
        end
        add_halt(2'b11, 3);
        return;
      end
      for (int k = 0; k <= dw; k++) begin
        r = mk(3'd4); r.exp.dmem_req = 1; r.exp.dmem_we = mw;
        if (k == dw) r.dmem_ack = 1;
        q.push_back(r);
      end
    end
    r = mk(3'd5); r.exp.rf_we = rw; r.exp.pc_we = 1; r.exp.retire = 1;
    r.exp.pc_sel = ps && (op != OP_BR || br);
    q.push_back(r);
    model_cnt = (model_cnt + 1) % (1 << DW);
  endfunction

  // ---------------- driver / checker ----------------
  task automatic step(input rec_t r);
    imem_ack_i = r.exp.imem_req ? r.imem_ack : 1'($urandom);
    dmem_ack_i = r.exp.dmem_req ? r.dmem_ack : 1'($urandom);
    opcode_i   = r.drive_dec ? r.opcode : 7'($urandom);
    {regwren_i, memren_i, memwren_i, pcsel_i} = r.drive_dec ? r.ctrl : 4'($urandom);
    br_taken_i = r.drive_exec ? r.br : 1'($urandom);
    @(negedge clk);
    chk("cycle_outputs", 32'(sample()), 32'(r.exp));
    if (imem_req_o) obs_imem++;
    if (dmem_req_o) obs_dmem++;
    if (pc_sel_o)   obs_pcsel++;
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n && q.size() > 0; i++) step(q.pop_front());
  endtask

  task automatic run_all();
    while (q.size() > 0) step(q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("reset_outputs", 32'(sample()), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_cnt = 0;
    q.push_back(mk(3'd0));   // one IDLE cycle before the first fetch
  endtask

  initial begin
    // ADDI from reset, ack in first fetch cycle
    do_reset();
    add_insn(OP_ADDI, 1, 0, 0, 0, 0, 0, 0);
    run_all();
    chk("addi_state_after_wb", 32'(state_o), 32'd1);
    chk("addi_instret", 32'(instret_o), 32'd1);

    // LW with three dmem wait cycles
    obs_dmem = 0;
    add_insn(OP_LD, 1, 1, 0, 0, 0, 0, 3);
    run_all();
    chk("lw_dmem_req_cycles", 32'(obs_dmem), 32'd4);

    // SW, a fetch wait, and a read+write decode that must act as a store
    add_insn(OP_ST, 0, 0, 1, 0, 0, 1, 0);
    add_insn(OP_ST, 0, 1, 1, 0, 0, 0, 1);

    // Branch not taken, taken, JAL, then LUI/R-type
    obs_pcsel = 0;
    add_insn(OP_BR,  0, 0, 0, 1, 0, 0, 0);
    add_insn(OP_BR,  0, 0, 0, 1, 1, 0, 0);
    add_insn(OP_JAL, 1, 0, 0, 1, 0, 0, 0);
    run_all();
    chk("branch_jal_pcsel_cycles", 32'(obs_pcsel), 32'd2);
    add_insn(OP_LUI, 1, 0, 0, 0, 1, 2, 0);
    add_insn(OP_R,   1, 0, 0, 0, 0, 0, 0);

    // Timeout boundaries: ack in cycle TO+1 still succeeds
    add_insn(OP_ADDI, 1, 0, 0, 0, 0, TO, 0);
    add_insn(OP_LD,   1, 1, 0, 0, 0, 0, TO);

    // Illegal opcode
    add_insn(OP_SYS, 1, 0, 0, 0, 0, 0, 0);
    run_all();
    chk("illegal_err", 32'(err_o), 32'd1);
    chk("illegal_halted", 32'(halted_o), 32'd1);

    // imem timeout
    do_reset();
    obs_imem = 0;
    add_insn(OP_ADDI, 1, 0, 0, 0, 0, TO + 1, 0);
    run_all();
    chk("imem_timeout_req_cycles", 32'(obs_imem), 32'd5);
    chk("imem_timeout_err", 32'(err_o), 32'd2);

    // dmem timeout
    do_reset();
    add_insn(OP_ST, 0, 0, 1, 0, 0, 0, TO + 1);
    run_all();
    chk("dmem_timeout_err", 32'(err_o), 32'd3);

    // Reset asserted mid-MEM
    do_reset();
    add_insn(OP_ADDI, 1, 0, 0, 0, 0, 0, 0);
    add_insn(OP_LD,   1, 1, 0, 0, 0, 0, 3);
    run_n(1 + 4 + 5);   // IDLE, ADDI, then F,D,E,M,M of the load
    q.delete();
    chk("mid_mem_req_before_reset", 32'(dmem_req_o), 32'd1);
    rst_n = 1'b0; #1;
    chk("mid_mem_req_in_reset", 32'(dmem_req_o), 32'd0);
    chk("mid_mem_state_in_reset", 32'(state_o), 32'd0);
    chk("mid_mem_instret_in_reset", 32'(instret_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_cnt = 0;
    q.push_back(mk(3'd0));
    add_insn(OP_ADDI, 1, 0, 0, 0, 0, 0, 0);
    run_all();
    chk("post_reset_err", 32'(err_o), 32'd0);

    // 16 retires wrap the 4-bit counter (one already retired above)
    for (int i = 0; i < 15; i++) add_insn((i % 2) ? OP_R : OP_ADDI, 1, 0, 0, 0, 0, 0, 0);
    run_all();
    chk("instret_wrap", 32'(instret_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop so a broken run still reports.
  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/insn_sequencer.md
# insn_sequencer

Multi-cycle instruction sequencer for the pd-series RISC-V core. It steps each instruction through FETCH, DECODE, EXECUTE, optional MEM and WRITEBACK. It handshakes with instruction and data memory, and latches the decode-stage control bits (regwren/memren/memwren/pcsel) so downstream enables are asserted only in the correct cycle. It also counts retired instructions and halts on illegal opcodes or memory timeouts.

## Interface
- `DWIDTH`, 32, width of the retire counter.
- `TIMEOUT`, 255, maximum wait cycles for a memory ack; must be 1..65535.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode_i`  in  7  opcode from decode; sampled in DECODE.
- `regwren_i`, `memren_i`, `memwren_i`, `pcsel_i`  in  1 each  control bits from decode; sampled in DECODE.
- `br_taken_i`  in  1  branch comparison result; sampled in EXECUTE.
- `imem_req_o`  out  1  instruction fetch request.
- `imem_ack_i`  in  1  fetch data valid.
- `dmem_req_o`  out  1  data access request.
- `dmem_we_o`  out  1  store when 1, load when 0.
- `dmem_ack_i`  in  1  data access complete.
- `ir_we_o`  out  1  instruction register load strobe.
- `rf_we_o`  out  1  register file write strobe.
- `pc_we_o`  out  1  PC update strobe.
- `pc_sel_o`  out  1  PC source: 1 = target, 0 = PC+4.
- `state_o`  out  3  current state.
- `retire_o`  out  1  instruction retired this cycle.
- `instret_o`  out  DWIDTH  count of retired instructions.
- `halted_o`  out  1  sticky halt flag.
- `err_o`  out  2  error code: 00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.

## Operation
State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.

- **IDLE:** all strobes 0. Always moves to FETCH on the next edge.
- **FETCH:**
  - `imem_req_o`=1 for every cycle spent here.
  - On `imem_ack_i`=1: `ir_we_o`=1 in the same cycle, then go to DECODE.
  - A wait counter increments on each FETCH cycle without ack. When it reaches TIMEOUT without ack: go to HALT with err=10.
- **DECODE:**
  - Latch `regwren_i`, `memren_i`, `memwren_i`, `pcsel_i` and `opcode_i`.
  - Legal opcodes are 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011. Any other opcode goes to HALT with err=01.
  - A legal opcode goes to EXEC.
- **EXEC:**
  - When the opcode is BRANCH (1100011), latch `br_taken_i`.
  - If memren|memwren was latched, go to MEM; otherwise go to WB.
- **MEM:**
  - `dmem_req_o`=1 and `dmem_we_o`=latched memwren, held stable until ack.
  - On `dmem_ack_i`, go to WB.
  - The timeout rule matches FETCH, with err=11.
  - If memren and memwren are both latched, the access is a store: `dmem_we_o`=1.
- **WB:** single cycle, then FETCH.
  - `rf_we_o` = latched regwren.
  - `pc_we_o`=1.
  - `pc_sel_o` = latched pcsel, masked by latched br_taken for BRANCH opcodes.
  - `retire_o`=1 and `instret_o` increments.
- **HALT:**
  - Terminal until reset.
  - `halted_o`=1 and `err_o` holds its code.
  - All strobes 0; `instret_o` is frozen.
- **Counters:**
  - The wait counter clears on every state entry.
  - `instret_o` wraps modulo 2^DWIDTH.
  - `pc_sel_o` is 0 in every state except WB.

## Timing
- **Reset:** while `rst_n`=0, the state is forced to IDLE immediately, independent of the clock. During and after reset:
  - `state_o`=0.
  - All strobes, `halted_o` and `err_o` are 0.
  - `instret_o`=0.
  - Latched control bits are cleared.
- **Reset mid-operation:** an in-flight memory request drops in the reset cycle; no write occurs.
- **Output timing:** all request and strobe outputs are combinational from the registered state plus acks. No output depends combinationally on `opcode_i` or the control inputs.
- **Latency with ack in the first request cycle:**
  - ALU, jump or branch instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 cycles.
  - Each wait cycle adds 1.
- **Timeout boundary:** with TIMEOUT=N, N consecutive un-acked request cycles are tolerated. An ack arriving in cycle N+1 still succeeds; with no ack by then, HALT is entered at the end of cycle N+1.
- **Same-cycle ack:** an ack in the same cycle as the request is legal. An ack when no request is outstanding is ignored.
- **First instruction:** the first FETCH occurs in the second cycle after reset release.

## Test plan
- **Reset release, ADDI (0010011, regwren=1), imem ack in the first cycle:** `state_o` runs 0,1,2,3,5,1. `rf_we_o` and `pc_we_o` are 1 only in the WB cycle; `pc_sel_o`=0. `instret_o` goes 0→1.
- **LW (memren=1) with dmem ack after 3 wait cycles:** `dmem_req_o`=1 for 4 cycles with `dmem_we_o`=0. WB follows with `rf_we_o`=1; total 8 cycles.
- **SW (memwren=1, regwren=0):** `dmem_we_o`=1 in MEM; `rf_we_o`=0 in WB; `retire_o`=1.
- **BRANCH with pcsel=1:**
  - `br_taken_i`=0 gives `pc_sel_o`=0 in WB.
  - `br_taken_i`=1 gives `pc_sel_o`=1.
  - JAL gives `pc_sel_o`=1 unconditionally.
- **Fault cases:**
  - Opcode 1110011: HALT with `err_o`=01, `halted_o`=1; no further `imem_req_o`.
  - TIMEOUT=4 with imem ack withheld: HALT with `err_o`=10 after 5 request cycles.
- **Reset and counter wrap:**
  - Assert `rst_n`=0 while in MEM: `dmem_req_o` drops immediately; after release the sequencer is back in IDLE, `instret_o`=0, `err_o`=00.
  - DWIDTH=4 with 16 retires: `instret_o` wraps to 0.
